line_buffer_fifo: RTL and testbench
===================================

Name: line_buffer_fifo

Overview:
- Synchronous word FIFO directly upstream of display_controller. It buffers pixel words arriving from the host/USB ingest side and exposes its fill level as num_words_in_buffer.
- display_controller uses that fill level to decide when a line of data is available, then drains words through the read port.
- Single clock domain (fpga_clk).

Parameters:
- DATA_WIDTH, 32, width of one buffered word in bits.
- DEPTH, 16, word capacity; must be a power of two, at most 16.
- CNT_WIDTH, 5, width of num_words_in_buffer; holds 0..DEPTH inclusive.

Ports:
- fpga_clk  input  1  system clock; all logic on rising edge.
- reset_all  input  1  asynchronous, active-low reset (asserted when 0).
- flush  input  1  synchronous clear of buffer contents.
- wr_en  input  1  write request from ingest side.
- wr_data  input  DATA_WIDTH  word to write.
- wr_ack  output  1  write accepted this cycle (combinational from wr_en and state).
- rd_en  input  1  read request from display side.
- rd_data  output  DATA_WIDTH  registered read word.
- rd_valid  output  1  rd_data valid, one cycle after an accepted read.
- num_words_in_buffer  output  CNT_WIDTH  current occupancy, registered.
- full  output  1  occupancy == DEPTH.
- empty  output  1  occupancy == 0.
- overflow  output  1  sticky: write attempted while full and not simultaneously read.
- underflow  output  1  sticky: read attempted while empty.
- clear_errors  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (reset_all=0, async): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. As a result full=0 and empty=1. RAM contents are not reset.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked in a separate CNT_WIDTH counter; full and empty are decoded from that counter, not from the pointers.
- Read acceptance: rd_accept = rd_en & ~empty.
- Write acceptance: wr_accept = wr_en & (~full | rd_accept). A write to a full FIFO is accepted only when a read is accepted in the same cycle.
- wr_ack = wr_accept.
- Accepted write: RAM[wr_ptr] <= wr_data; wr_ptr increments.
- Accepted read: rd_data <= RAM[rd_ptr]; rd_valid=1 next cycle; rd_ptr increments. Read latency is exactly 1 cycle.
- When no read is accepted, rd_valid=0 and rd_data holds its last value.
- Count update each cycle: +1 on write only, -1 on read only, unchanged on both or neither. The count never exceeds DEPTH and never goes below 0.
- Read and write in the same cycle with count==0: read rejected, write accepted, count becomes 1. There is no write-through bypass; the word becomes readable the following cycle.
- Read and write in the same cycle with count==DEPTH: both accepted, count stays DEPTH. The read returns the oldest word, not the incoming one.
- Overflow set on: wr_en & full & ~rd_accept.
- Underflow set on: rd_en & empty.
- Both error flags hold until clear_errors=1 or reset. If clear_errors and a new error occur in the same cycle, the set wins.
- Flush (synchronous, highest priority after reset): wr_ptr=rd_ptr=0, count=0, rd_valid=0. wr_en and rd_en are ignored that cycle, wr_ack=0, and error flags are unchanged.
- Reset asserted mid-operation returns all state to reset values immediately. The first accepted write after reset deasserts lands at address 0.
- num_words_in_buffer, full and empty are registered from the count and therefore reflect the previous edge. wr_ack is the only combinational output.

Decomposition:
- Shared package display_pkg holds:
  - constants LINE_WORD_WIDTH=32 and LINE_BUF_DEPTH=16;
  - the count width derived from depth (clog2(DEPTH)+1);
  - these so that display_controller and this block agree on num_words_in_buffer width.
- One sub-module, line_buffer_ram: simple dual-port RAM with one write port and one registered read port, DATA_WIDTH x DEPTH, no reset. It is inferable as block RAM or registers.
- Pointers, counter, flags and handshake logic stay in line_buffer_fifo.

Test Plan:
- Reset then idle -> num_words_in_buffer=0, empty=1, full=0, rd_valid=0, overflow=underflow=0.
- Write 16 words 0x00000000..0x0000000F back-to-back -> count steps 1..16, full=1 after the 16th. A 17th wr_en with no read -> wr_ack=0, overflow=1, count stays 16.
- From full, rd_en for 16 cycles -> rd_valid each following cycle with rd_data 0x0..0xF in order. empty=1 at the end; one extra rd_en -> underflow=1, rd_valid=0.
- At count=16, simultaneous wr_en (0xAAAA5555) and rd_en -> wr_ack=1, count stays 16, rd_data = oldest word. Drain 16 more words -> 0xAAAA5555 is the last one out (checks pointer wrap).
- At count=0, simultaneous wr_en (0x12345678) and rd_en -> read rejected, underflow=1, count=1. Next-cycle rd_en -> rd_data=0x12345678.
- Load 7 words, pulse flush with wr_en=1 and rd_en=1 -> count=0, wr_ack=0, rd_valid=0, sticky flags unchanged. Then assert reset_all=0 asynchronously mid-burst -> all outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared line-buffer sizing so display_controller and line_buffer_fifo
// agree on word width, depth and the num_words_in_buffer width.
package display_pkg;

  localparam int LINE_WORD_WIDTH    = 32;
  localparam int LINE_BUF_DEPTH     = 16;
  localparam int LINE_BUF_CNT_WIDTH = $clog2(LINE_BUF_DEPTH) + 1;

  typedef logic [LINE_BUF_CNT_WIDTH-1:0] line_count_t;

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port storage for the line buffer: one write port, one
// registered read port, no reset so it maps onto block RAM or registers.
module line_buffer_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A read and write to the same address return the old word, which is
  // what the FIFO relies on when it is full and both ports fire.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/line_buffer_fifo.sv
// Word FIFO feeding display_controller; occupancy is kept in its own
// counter and exported as num_words_in_buffer.
module line_buffer_fifo
  import display_pkg::*;
#(
  parameter int DATA_WIDTH = LINE_WORD_WIDTH,
  parameter int DEPTH      = LINE_BUF_DEPTH,
  parameter int CNT_WIDTH  = LINE_BUF_CNT_WIDTH
) (
  input  logic                  fpga_clk,
  input  logic                  reset_all,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  num_words_in_buffer,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_errors
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  rd_seen;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign rd_accept = rd_en & ~empty & ~flush;
  assign wr_accept = wr_en & (~full | rd_accept) & ~flush;

  assign wr_ack              = wr_accept;
  assign num_words_in_buffer = count;

  // The RAM read register has no reset, so rd_data is forced to zero until
  // the first accepted read after reset has loaded it.
  assign rd_data = rd_seen ? ram_rd_data : '0;

  line_buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (fpga_clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_seen  <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr  <= rd_ptr + PTR_WIDTH'(1);
        rd_seen <= 1'b1;
      end
      rd_valid <= rd_accept;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clear_errors wins,
  // and a flush cycle leaves them untouched.
  always_ff @(posedge fpga_clk or negedge reset_all) begin
    if (!reset_all) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      if (wr_en & full & ~rd_accept) begin
        overflow <= 1'b1;
      end else if (clear_errors) begin
        overflow <= 1'b0;
      end
      if (rd_en & empty) begin
        underflow <= 1'b1;
      end else if (clear_errors) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_fifo.sv
// Self-checking bench for line_buffer_fifo: vector table for the fill/drain
// walk, hand sequences for the corner cases, scoreboard for read data.
module tb_line_buffer_fifo;

  logic        fpga_clk = 1'b0;
  logic        reset_all;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  num_words_in_buffer;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;
  logic        clear_errors;

  typedef struct {
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic        flush;
    logic        clr;
    logic        exp_ack;
    logic        exp_rd_acc;
    int          exp_count;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_q[$];
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  line_buffer_fifo dut (
    .fpga_clk            (fpga_clk),
    .reset_all           (reset_all),
    .flush               (flush),
    .wr_en               (wr_en),
    .wr_data             (wr_data),
    .wr_ack              (wr_ack),
    .rd_en               (rd_en),
    .rd_data             (rd_data),
    .rd_valid            (rd_valid),
    .num_words_in_buffer (num_words_in_buffer),
    .full                (full),
    .empty               (empty),
    .overflow            (overflow),
    .underflow           (underflow),
    .clear_errors        (clear_errors)
  );

  always #5 fpga_clk = ~fpga_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(logic wr, logic [31:0] d, logic rd, logic fl,
                                 logic clr, logic ack, logic racc, int cnt,
                                 logic ovf, logic unf);
    vec_t v;
    v.wr_en = wr; v.wr_data = d; v.rd_en = rd; v.flush = fl; v.clr = clr;
    v.exp_ack = ack; v.exp_rd_acc = racc; v.exp_count = cnt;
    v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    checkVal("count", 32'(num_words_in_buffer), v.exp_count);
    checkVal("full", 32'(full), 32'(v.exp_count == 16));
    checkVal("empty", 32'(empty), 32'(v.exp_count == 0));
    checkVal("overflow", 32'(overflow), 32'(v.exp_ovf));
    checkVal("underflow", 32'(underflow), 32'(v.exp_unf));
    checkVal("rd_valid", 32'(rd_valid), 32'(v.exp_rd_acc));
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        checkVal("rd_data_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        checkVal("rd_data", rd_data, sb_q.pop_front());
      end
    end
  endtask

  // Called at posedge+1: drives one cycle, checks wr_ack, then the edge.
  task automatic applyStimulus(input vec_t v);
    wr_en = v.wr_en; wr_data = v.wr_data; rd_en = v.rd_en;
    flush = v.flush; clear_errors = v.clr;
    #1;
    checkVal("wr_ack", 32'(wr_ack), 32'(v.exp_ack));
    if (v.flush) model_q.delete();
    if (v.exp_rd_acc) sb_q.push_back(model_q.pop_front());
    if (v.exp_ack) model_q.push_back(v.wr_data);
    @(posedge fpga_clk);
    #1;
    checkOutput(v);
  endtask

  initial begin
    reset_all = 1'b0; flush = 0; wr_en = 0; wr_data = '0; rd_en = 0;
    clear_errors = 0;
    repeat (2) @(posedge fpga_clk);
    #1;
    reset_all = 1'b1;

    // Fill to full, overflow, drain, underflow, clear.
    vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mkVec(1, 32'(i), 0, 0, 0, 1, 0, i + 1, 0, 0));
    vecs.push_back(mkVec(1, 32'hDEAD0000, 0, 0, 0, 0, 0, 16, 1, 0));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 1, 15 - i, 1, 0));
    vecs.push_back(mkVec(0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mkVec(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Full with simultaneous read/write, then drain across the pointer wrap.
    for (int i = 0; i < 16; i++)
      applyStimulus(mkVec(1, 32'h100 + 32'(i), 0, 0, 0, 1, 0, i + 1, 0, 0));
    applyStimulus(mkVec(1, 32'hAAAA5555, 1, 0, 0, 1, 1, 16, 0, 0));
    for (int i = 0; i < 16; i++)
      applyStimulus(mkVec(0, 0, 1, 0, 0, 0, 1, 15 - i, 0, 0));

    // Empty with simultaneous read/write: read rejected, no bypass.
    applyStimulus(mkVec(1, 32'h12345678, 1, 0, 0, 1, 0, 1, 0, 1));
    applyStimulus(mkVec(0, 0, 1, 0, 0, 0, 1, 0, 0, 1));

    // Flush ignores both requests and keeps the sticky underflow.
    for (int i = 0; i < 7; i++)
      applyStimulus(mkVec(1, 32'h700 + 32'(i), 0, 0, 0, 1, 0, i + 1, 0, 1));
    applyStimulus(mkVec(1, 32'hBAD0BAD0, 1, 1, 0, 0, 0, 0, 0, 1));
    applyStimulus(mkVec(1, 32'h00000077, 0, 0, 0, 1, 0, 1, 0, 1));
    applyStimulus(mkVec(0, 0, 1, 0, 0, 0, 1, 0, 0, 1));

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++)
      applyStimulus(mkVec(1, 32'h31 + 32'(i), 0, 0, 0, 1, 0, i + 1, 0, 1));
    applyStimulus(mkVec(0, 0, 1, 0, 0, 0, 1, 2, 0, 1));
    wr_en = 1; wr_data = 32'h34; rd_en = 1;
    #2;
    reset_all = 1'b0;
    #1;
    checkVal("rst_count", 32'(num_words_in_buffer), 32'd0);
    checkVal("rst_empty", 32'(empty), 32'd1);
    checkVal("rst_full", 32'(full), 32'd0);
    checkVal("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkVal("rst_overflow", 32'(overflow), 32'd0);
    checkVal("rst_underflow", 32'(underflow), 32'd0);
    checkVal("rst_rd_data", rd_data, 32'd0);
    wr_en = 0; rd_en = 0;
    @(posedge fpga_clk);
    #1;
    reset_all = 1'b1;
    model_q.delete();
    sb_q.delete();
    applyStimulus(mkVec(1, 32'hCAFEF00D, 0, 0, 0, 1, 0, 1, 0, 0));
    applyStimulus(mkVec(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

    checkVal("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
